// File: rtl/mton_fifo_rr_if.sv
// Bundle of the write-side and read-side handshake signals of mton_fifo_rr.
//   slave  : the FIFO itself (takes pushes and read requests, drives acks, flags and data)
//   master : the surrounding logic (drives pushes and read requests)
// Write-side signals belong to the write clock domain, read-side signals to the read domain.
interface mton_fifo_rr_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AW        = 4,
  parameter int unsigned M_WRITERS = 4,
  parameter int unsigned N_READERS = 3
);
  logic [M_WRITERS-1:0]       wr_en;
  logic [M_WRITERS*WIDTH-1:0] wr_data;
  logic [M_WRITERS-1:0]       wr_ack;
  logic                       wr_full;
  logic                       wr_pfull;
  logic [AW:0]                wr_remain;
  logic [N_READERS-1:0]       rd_req;
  logic [N_READERS-1:0]       rd_gnt;
  logic [N_READERS*WIDTH-1:0] rd_data;
  logic [N_READERS-1:0]       rd_valid;
  logic                       rd_empty;
  logic                       rd_pempty;
  logic [AW:0]                rd_level;
  logic                       rd_pend;

  modport master (
    output wr_en, wr_data, rd_req,
    input  wr_ack, wr_full, wr_pfull, wr_remain,
    input  rd_gnt, rd_data, rd_valid, rd_empty, rd_pempty, rd_level, rd_pend
  );

  modport slave (
    input  wr_en, wr_data, rd_req,
    output wr_ack, wr_full, wr_pfull, wr_remain,
    output rd_gnt, rd_data, rd_valid, rd_empty, rd_pempty, rd_level, rd_pend
  );
endinterface

// File: rtl/mton_fifo_rr.sv
// Dual-clock packet FIFO: M_WRITERS lanes are packed into one packet per write-clock cycle,
// and the lanes of each packet are handed out one per read-clock cycle to N_READERS readers
// arbitrated round-robin.
// Ports:
//   i_wr_clk / i_wr_rstn : write clock, asynchronous active-low write reset
//   i_rd_clk / i_rd_rstn : read clock, asynchronous active-low read reset
//   bus (slave)          : wr_en/wr_data/wr_ack/wr_full/wr_pfull/wr_remain (write domain),
//                          rd_req/rd_gnt/rd_data/rd_valid/rd_empty/rd_pempty/rd_level/rd_pend
//                          (read domain)
module mton_fifo_rr #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned AW        = 4,
  parameter int unsigned M_WRITERS = 4,
  parameter int unsigned N_READERS = 3,
  parameter int unsigned PFULL_TH  = 4,
  parameter int unsigned PEMPTY_TH = 4
) (
  input logic           i_wr_clk,
  input logic           i_wr_rstn,
  input logic           i_rd_clk,
  input logic           i_rd_rstn,
  mton_fifo_rr_if.slave bus
);

  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned DataW = M_WRITERS * WIDTH;
  localparam int unsigned PktW  = DataW + M_WRITERS;
  localparam int unsigned RrW   = (N_READERS > 1) ? $clog2(N_READERS) : 1;
  localparam int unsigned LaneW = (M_WRITERS > 1) ? $clog2(M_WRITERS) : 1;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);
  // Gray pointers that differ only in their two MSBs are a full lap apart.
  localparam logic [AW:0] FullMask = (AW + 1)'(3) << (AW - 1);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = int'(AW) - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Packet layout: {lane mask, lane data}; mask in the top M_WRITERS bits.
  logic [PktW-1:0] mem_q [Depth];

  // ---------------------------------------------------------------- write domain
  logic [AW:0]          wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
  logic [AW:0]          rd_gray_s1_q, rd_gray_s2_q;
  logic                 wr_full_q, wr_full_d, wr_pfull_q, wr_pfull_d;
  logic [AW:0]          wr_remain_q, wr_remain_d;
  logic [M_WRITERS-1:0] wr_ack;
  logic                 wr_push;
  logic [PktW-1:0]      wr_pkt;

  always_comb begin
    wr_ack  = bus.wr_en & {M_WRITERS{~wr_full_q}};
    wr_push = |wr_ack;
    wr_pkt  = '0;
    wr_pkt[PktW-1 -: M_WRITERS] = wr_ack;
    for (int k = 0; k < int'(M_WRITERS); k++) begin
      if (wr_ack[k]) wr_pkt[k*WIDTH +: WIDTH] = bus.wr_data[k*WIDTH +: WIDTH];
    end
    wr_bin_d    = wr_bin_q + {{AW{1'b0}}, wr_push};
    wr_gray_d   = bin2gray(wr_bin_d);
    // Flags are computed from the next pointer so they are valid the cycle after a push.
    wr_full_d   = (wr_gray_d == (rd_gray_s2_q ^ FullMask));
    wr_remain_d = DepthCnt - (wr_bin_d - gray2bin(rd_gray_s2_q));
    wr_pfull_d  = (32'(wr_remain_d) <= PFULL_TH);
  end

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      wr_bin_q     <= '0;
      wr_gray_q    <= '0;
      rd_gray_s1_q <= '0;
      rd_gray_s2_q <= '0;
      wr_full_q    <= 1'b0;
      wr_pfull_q   <= 1'b0;
      wr_remain_q  <= DepthCnt;
    end else begin
      rd_gray_s1_q <= rd_gray_q;
      rd_gray_s2_q <= rd_gray_s1_q;
      wr_bin_q     <= wr_bin_d;
      wr_gray_q    <= wr_gray_d;
      wr_full_q    <= wr_full_d;
      wr_pfull_q   <= wr_pfull_d;
      wr_remain_q  <= wr_remain_d;
    end
  end

  always_ff @(posedge i_wr_clk) begin
    if (wr_push) mem_q[wr_bin_q[AW-1:0]] <= wr_pkt;
  end

  assign bus.wr_ack    = wr_ack;
  assign bus.wr_full   = wr_full_q;
  assign bus.wr_pfull  = wr_pfull_q;
  assign bus.wr_remain = wr_remain_q;

  // ----------------------------------------------------------------- read domain
  typedef enum logic [1:0] {StIdle, StCap, StHave, StPop} rd_state_e;

  rd_state_e                  state_q;
  logic [AW:0]                rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
  logic [AW:0]                wr_gray_s1_q, wr_gray_s2_q;
  logic                       rd_empty_q, rd_empty_d, rd_pempty_q, rd_pempty_d;
  logic [AW:0]                rd_level_q, rd_level_d;
  logic [PktW-1:0]            packet_q, head_pkt;
  logic [M_WRITERS-1:0]       consumed_q, head_mask, remaining, lane_hot;
  logic [LaneW-1:0]           lane_idx;
  logic [WIDTH-1:0]           lane_data;
  logic                       lane_last;
  logic [RrW-1:0]             rr_last_q, gnt_idx;
  logic                       gnt_any, pop;
  int                         rr_cand;
  logic [N_READERS-1:0]       rd_gnt_q, rd_valid_q;
  logic [N_READERS*WIDTH-1:0] rd_data_q;

  always_comb begin
    head_pkt  = mem_q[rd_bin_q[AW-1:0]];
    head_mask = head_pkt[PktW-1 -: M_WRITERS];
    remaining = packet_q[PktW-1 -: M_WRITERS] & ~consumed_q;
    // Isolate the lowest pending lane; it is the last one when nothing else remains.
    lane_hot  = remaining & (~remaining + M_WRITERS'(1));
    lane_last = (remaining == lane_hot);
    lane_idx  = '0;
    for (int k = 0; k < int'(M_WRITERS); k++) begin
      if (lane_hot[k]) lane_idx = LaneW'(k);
    end
    lane_data = packet_q[lane_idx*WIDTH +: WIDTH];

    // Round-robin: scan starting one past the last granted reader.
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_cand = 0;
    for (int k = 1; k <= int'(N_READERS); k++) begin
      rr_cand = (int'(rr_last_q) + k) % int'(N_READERS);
      if (!gnt_any && bus.rd_req[rr_cand]) begin
        gnt_any = 1'b1;
        gnt_idx = RrW'(rr_cand);
      end
    end

    pop = ((state_q == StHave) && gnt_any && lane_last) ||
          ((state_q == StCap) && (head_mask == '0));
    rd_bin_d    = rd_bin_q + {{AW{1'b0}}, pop};
    rd_gray_d   = bin2gray(rd_bin_d);
    rd_empty_d  = (rd_gray_d == wr_gray_s2_q);
    rd_level_d  = gray2bin(wr_gray_s2_q) - rd_bin_d;
    rd_pempty_d = (32'(rd_level_d) <= PEMPTY_TH);
  end

  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      state_q      <= StIdle;
      rd_bin_q     <= '0;
      rd_gray_q    <= '0;
      wr_gray_s1_q <= '0;
      wr_gray_s2_q <= '0;
      rd_empty_q   <= 1'b1;
      rd_pempty_q  <= 1'b1;
      rd_level_q   <= '0;
      packet_q     <= '0;
      consumed_q   <= '0;
      rr_last_q    <= RrW'(N_READERS - 1);
      rd_gnt_q     <= '0;
      rd_valid_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      wr_gray_s1_q <= wr_gray_q;
      wr_gray_s2_q <= wr_gray_s1_q;
      rd_bin_q     <= rd_bin_d;
      rd_gray_q    <= rd_gray_d;
      rd_empty_q   <= rd_empty_d;
      rd_pempty_q  <= rd_pempty_d;
      rd_level_q   <= rd_level_d;
      // Delivery outputs are single-cycle pulses.
      rd_gnt_q     <= '0;
      rd_valid_q   <= '0;
      rd_data_q    <= '0;
      unique case (state_q)
        StIdle: if (!rd_empty_q) state_q <= StCap;
        StCap: begin
          packet_q   <= head_pkt;
          consumed_q <= '0;
          state_q    <= (head_mask == '0) ? StPop : StHave;
        end
        StHave: begin
          if (gnt_any) begin
            rd_gnt_q[gnt_idx]                 <= 1'b1;
            rd_valid_q[gnt_idx]               <= 1'b1;
            rd_data_q[gnt_idx*WIDTH +: WIDTH] <= lane_data;
            consumed_q                        <= consumed_q | lane_hot;
            rr_last_q                         <= gnt_idx;
            if (lane_last) state_q <= StPop;
          end
        end
        StPop: state_q <= rd_empty_q ? StIdle : StCap;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_gnt    = rd_gnt_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_empty  = rd_empty_q;
  assign bus.rd_pempty = rd_pempty_q;
  assign bus.rd_level  = rd_level_q;
  assign bus.rd_pend   = (state_q == StHave);

endmodule

// File: tb/tb_mton_fifo_rr.sv
// Self-checking bench for mton_fifo_rr: directed scenarios plus randomized traffic at two
// clock ratios, checked against a lane queue and a round-robin reader model.
module tb_mton_fifo_rr;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned M     = 4;
  localparam int unsigned N     = 3;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic wr_rstn = 1'b0;
  logic rd_rstn = 1'b0;
  int   wr_half = 5;
  int   rd_half = 5;
  int   tests = 0;
  int   fails = 0;

  mton_fifo_rr_if #(.WIDTH(WIDTH), .AW(AW), .M_WRITERS(M), .N_READERS(N)) bus ();

  mton_fifo_rr #(
    .WIDTH(WIDTH), .AW(AW), .M_WRITERS(M), .N_READERS(N), .PFULL_TH(4), .PEMPTY_TH(4)
  ) dut (
    .i_wr_clk (wr_clk),
    .i_wr_rstn(wr_rstn),
    .i_rd_clk (rd_clk),
    .i_rd_rstn(rd_rstn),
    .bus      (bus)
  );

  always #(wr_half) wr_clk = ~wr_clk;
  initial begin
    #2;
    forever #(rd_half) rd_clk = ~rd_clk;
  end

  // Reference model: expected lanes in delivery order, last granted reader.
  logic [WIDTH-1:0] exp_q[$];
  int               got_rdr[$];
  logic [WIDTH-1:0] got_data[$];
  logic [N-1:0]     req_edge;
  int               last_rr = N - 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge rd_clk) req_edge <= bus.rd_req;

  always @(negedge rd_clk) begin : monitor
    int                   r;
    int                   exp_r;
    logic [N*WIDTH-1:0]   others;
    if (!rd_rstn) begin
      last_rr = N - 1;
    end else if (bus.rd_valid != '0 || bus.rd_gnt != '0) begin
      check("gnt_onehot", $countones(bus.rd_gnt), 1);
      check("valid_eq_gnt", bus.rd_valid, bus.rd_gnt);
      r = 0;
      for (int k = 0; k < N; k++) if (bus.rd_gnt[k]) r = k;
      exp_r = -1;
      for (int k = 1; k <= N; k++) begin
        if (exp_r < 0 && req_edge[(last_rr + k) % N]) exp_r = (last_rr + k) % N;
      end
      check("rr_pick", r, exp_r);
      last_rr = r;
      check("lane_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("lane_data", bus.rd_data[r*WIDTH +: WIDTH], exp_q.pop_front());
      others = bus.rd_data;
      others[r*WIDTH +: WIDTH] = '0;
      check("other_slots_zero", others, 0);
      got_rdr.push_back(r);
      got_data.push_back(bus.rd_data[r*WIDTH +: WIDTH]);
    end else begin
      check("idle_data_zero", bus.rd_data, 0);
    end
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_gnt"}, bus.rd_gnt, 0);
    check({pfx, "_valid"}, bus.rd_valid, 0);
    check({pfx, "_data"}, bus.rd_data, 0);
    check({pfx, "_empty"}, bus.rd_empty, 1);
    check({pfx, "_pempty"}, bus.rd_pempty, 1);
    check({pfx, "_level"}, bus.rd_level, 0);
    check({pfx, "_pend"}, bus.rd_pend, 0);
    check({pfx, "_full"}, bus.wr_full, 0);
    check({pfx, "_pfull"}, bus.wr_pfull, 0);
    check({pfx, "_remain"}, bus.wr_remain, 16);
  endtask

  task automatic do_reset();
    bus.wr_en = '0;
    bus.wr_data = '0;
    bus.rd_req = '0;
    wr_rstn = 1'b0;
    rd_rstn = 1'b0;
    repeat (3) @(negedge rd_clk);
    check_reset_vals("in_reset");
    #1;
    wr_rstn = 1'b1;
    rd_rstn = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge rd_clk);
    check_reset_vals("after_reset");
  endtask

  task automatic write_pkt(input logic [M-1:0] mask, input logic [M*WIDTH-1:0] data,
                           input bit expect_ok);
    int budget;
    @(negedge wr_clk);
    if (expect_ok) begin
      budget = 0;
      while (bus.wr_full && budget < 2000) begin
        @(negedge wr_clk);
        budget++;
      end
      check("wr_room_timeout", (budget < 2000), 1);
    end
    bus.wr_en = mask;
    bus.wr_data = data;
    #1;
    check("wr_ack", bus.wr_ack, expect_ok ? mask : {M{1'b0}});
    if (expect_ok) begin
      for (int k = 0; k < M; k++) if (mask[k]) exp_q.push_back(data[k*WIDTH +: WIDTH]);
    end
    @(posedge wr_clk);
    #1;
    bus.wr_en = '0;
  endtask

  task automatic drain(input logic [N-1:0] req);
    int budget;
    budget = 0;
    @(negedge rd_clk);
    bus.rd_req = req;
    while (exp_q.size() != 0 && budget < 4000) begin
      @(negedge rd_clk);
      budget++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (8) @(negedge rd_clk);
    bus.rd_req = '0;
    check("drained_empty", bus.rd_empty, 1);
    check("drained_level", bus.rd_level, 0);
    check("drained_pend", bus.rd_pend, 0);
    repeat (6) @(negedge wr_clk);
    check("drained_remain", bus.wr_remain, 16);
    check("drained_full", bus.wr_full, 0);
  endtask

  task automatic random_phase(input int wh, input int rh);
    bit wr_done;
    wr_done = 1'b0;
    wr_half = wh;
    rd_half = rh;
    repeat (4) @(negedge rd_clk);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [M-1:0]       mask;
          logic [M*WIDTH-1:0] d;
          mask = M'($urandom_range(1, 15));
          d = $urandom;
          repeat ($urandom_range(0, 2)) @(negedge wr_clk);
          write_pkt(mask, d, 1'b1);
        end
        wr_done = 1'b1;
      end
      begin
        int budget;
        budget = 0;
        while (!(wr_done && exp_q.size() == 0) && budget < 20000) begin
          @(negedge rd_clk);
          bus.rd_req = N'($urandom_range(0, 7));
          budget++;
        end
        check("rand_timeout", (budget < 20000), 1);
      end
    join
    drain(3'b111);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();

    // Three readers always requesting share one 4-lane packet round-robin.
    got_rdr.delete();
    got_data.delete();
    @(negedge rd_clk);
    bus.rd_req = 3'b111;
    write_pkt(4'b1111, 32'h1312_1110, 1'b1);
    drain(3'b111);
    check("rr_count", got_rdr.size(), 4);
    if (got_rdr.size() == 4) begin
      check("rr_seq0", got_rdr[0], 0);
      check("rr_seq1", got_rdr[1], 1);
      check("rr_seq2", got_rdr[2], 2);
      check("rr_seq3", got_rdr[3], 0);
      for (int k = 0; k < 4; k++) check("rr_data", got_data[k], 8'h10 + k);
    end

    // Sparse mask: only lanes 0 and 2 are delivered, to reader 0.
    got_rdr.delete();
    got_data.delete();
    @(negedge rd_clk);
    bus.rd_req = 3'b001;
    write_pkt(4'b0101, 32'hD3C2_B1A0, 1'b1);
    drain(3'b001);
    check("sparse_count", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("sparse_d0", got_data[0], 8'hA0);
      check("sparse_d1", got_data[1], 8'hC2);
      check("sparse_r0", got_rdr[0], 0);
      check("sparse_r1", got_rdr[1], 0);
    end

    // Fill to full with no reader, then attempt an overflow write.
    @(negedge rd_clk);
    bus.rd_req = '0;
    for (int i = 0; i < 16; i++) begin
      write_pkt(4'b1111, $urandom, 1'b1);
      check("fill_remain", bus.wr_remain, 15 - i);
      check("fill_pfull", bus.wr_pfull, ((15 - i) <= 4));
      check("fill_full", bus.wr_full, (i == 15));
    end
    repeat (4) @(negedge wr_clk);
    check("full_flag", bus.wr_full, 1);
    check("full_remain", bus.wr_remain, 0);
    write_pkt(4'b1111, 32'hDEAD_BEEF, 1'b0);
    check("ovf_remain", bus.wr_remain, 0);
    check("ovf_full", bus.wr_full, 1);
    repeat (8) @(negedge rd_clk);
    check("full_level", bus.rd_level, 16);
    check("full_pempty", bus.rd_pempty, 0);
    drain(3'b111);

    // Level 3 -> 5: programmable-empty must drop within three read clocks.
    for (int i = 0; i < 3; i++) write_pkt(4'b0001, $urandom, 1'b1);
    repeat (8) @(negedge rd_clk);
    check("pe_level3", bus.rd_level, 3);
    check("pe_pempty3", bus.rd_pempty, 1);
    write_pkt(4'b0001, $urandom, 1'b1);
    write_pkt(4'b0001, $urandom, 1'b1);
    n = 0;
    while (bus.rd_pempty !== 1'b0 && n < 8) begin
      @(posedge rd_clk);
      n++;
      #1;
    end
    check("pe_latency_ok", (n <= 3), 1);
    repeat (4) @(negedge rd_clk);
    check("pe_level5", bus.rd_level, 5);
    check("pe_pempty5", bus.rd_pempty, 0);
    drain(3'b111);

    // Randomized traffic at both clock ratios; pointers wrap over the 80 packets.
    random_phase(5, 15);
    random_phase(15, 5);
    wr_half = 5;
    rd_half = 5;
    repeat (4) @(negedge rd_clk);

    // Read reset while a captured packet still has unconsumed lanes.
    got_data.delete();
    got_rdr.delete();
    write_pkt(4'b0111, 32'h0033_2211, 1'b1);
    n = 0;
    while (bus.rd_pend !== 1'b1 && n < 50) begin
      @(negedge rd_clk);
      n++;
    end
    check("mid_pend_seen", (n < 50), 1);
    bus.rd_req = 3'b001;
    @(negedge rd_clk);
    bus.rd_req = '0;
    #1;
    check("mid_one_lane", got_data.size(), 1);
    check("mid_still_pend", bus.rd_pend, 1);
    #2;
    rd_rstn = 1'b0;
    #1;
    check("rrst_gnt", bus.rd_gnt, 0);
    check("rrst_valid", bus.rd_valid, 0);
    check("rrst_data", bus.rd_data, 0);
    check("rrst_pend", bus.rd_pend, 0);
    @(negedge rd_clk);
    check("rrst_edge_valid", bus.rd_valid, 0);
    check("rrst_edge_data", bus.rd_data, 0);
    check("rrst_empty", bus.rd_empty, 1);
    check("rrst_pempty", bus.rd_pempty, 1);
    check("rrst_level", bus.rd_level, 0);
    check("rrst_known", $isunknown({bus.rd_empty, bus.rd_pempty, bus.rd_pend, bus.rd_level,
                                    bus.rd_gnt, bus.rd_valid}), 0);
    exp_q.delete();
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mton_fifo_rr.md
MTON_FIFO_RR -- requirements
Module: mton_fifo_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning lane data width in bits.
REQ-002 The block SHALL have parameter AW, default 4, meaning address width; the block holds 2^AW packets.
REQ-003 The block SHALL have parameter M_WRITERS, default 4, meaning number of write lanes packed per packet.
REQ-004 The block SHALL have parameter N_READERS, default 3, meaning number of reader ports arbitrated round-robin.
REQ-005 The block SHALL have parameters PFULL_TH and PEMPTY_TH, default 4 each, meaning the programmable-full and programmable-empty thresholds in packets.
REQ-006 The read-side clock and reset SHALL be: i_rd_clk input 1 read clock; i_rd_rstn input 1 reset i_rd_rstn, asynchronous, active-low.
REQ-007 The write-side clock and reset SHALL be: i_wr_clk input 1 write clock; i_wr_rstn input 1 asynchronous active-low write reset.
REQ-008 The write-side ports SHALL be: i_wr_en input M_WRITERS lane push requests; i_wr_data input M_WRITERS*WIDTH lane data, lane k at bits [k*WIDTH +: WIDTH].
REQ-009 The write-side ports SHALL also be: o_wr_ack output M_WRITERS accepted lanes; o_wr_full, o_wr_pfull output 1 each; o_wr_remain output AW+1 free packets.
REQ-010 The read-side ports SHALL be: i_rd_req input N_READERS read requests; o_rd_gnt output N_READERS one-hot grant, registered.
REQ-011 The read-side ports SHALL also be: o_rd_data output N_READERS*WIDTH per-reader data, registered; o_rd_valid output N_READERS registered.
REQ-012 The read-side ports SHALL also be: o_rd_empty, o_rd_pempty output 1 each; o_rd_level output AW+1 stored packets; o_rd_pend output 1, high when a captured packet has unconsumed lanes.

Function
REQ-013 A write SHALL occur when |i_wr_en && !o_wr_full; o_wr_ack SHALL equal i_wr_en & {~o_wr_full}, combinationally.
REQ-014 Each written packet SHALL store the M_WRITERS*WIDTH data with non-acked lanes zeroed, plus an M_WRITERS-bit lane mask equal to o_wr_ack.
REQ-015 Pointers SHALL be AW+1-bit binary counters, Gray-encoded and crossed through 2-flop synchronizers; the counters SHALL wrap modulo 2^(AW+1).
REQ-016 o_wr_full SHALL assert when the write Gray pointer equals the synchronized read pointer with the two MSBs inverted.
REQ-017 o_wr_remain SHALL equal 2^AW minus the packet count; o_wr_pfull SHALL assert when o_wr_remain <= PFULL_TH.
REQ-018 o_rd_empty SHALL assert when the read Gray pointer equals the synchronized write pointer.
REQ-019 o_rd_pempty SHALL assert when o_rd_level <= PEMPTY_TH.
REQ-020 Flag and count outputs SHALL be registered in their own clock domain.
REQ-021 The read FSM SHALL have states IDLE, CAP, HAVE and POP.
REQ-022 In IDLE, when !o_rd_empty the FSM SHALL go to CAP.
REQ-023 In CAP, the FSM SHALL register the head packet into packet_q, clear consumed_q and go to HAVE; a head mask of 0 SHALL cause a pop without delivery.
REQ-024 In HAVE, when |i_rd_req the FSM SHALL grant exactly one reader, selected round-robin starting after the last granted index.
REQ-025 On a grant, the block SHALL deliver the lowest-index lane with mask & ~consumed_q set and mark that lane consumed.
REQ-026 Next cycle after a grant, o_rd_gnt[r], o_rd_valid[r] and o_rd_data[r] SHALL carry that lane; the slots of all other readers SHALL hold 0.
REQ-027 When the grant consumes the final valid lane, the block SHALL pulse the pop and go to POP in the same cycle.
REQ-028 In POP, the FSM SHALL go to CAP when !o_rd_empty, otherwise to IDLE.
REQ-029 The round-robin pointer SHALL advance only on a grant; requests in CAP, POP or IDLE SHALL receive no grant and SHALL not be queued.
REQ-030 Lane order out SHALL equal ascending lane index within a packet and packet order equal write order.

Reset
REQ-031 While i_rd_rstn is low, the read side SHALL be held in reset: state IDLE, read pointer 0, packet_q 0, consumed_q 0, RR pointer so that reader 0 wins first, all o_rd_* 0, o_rd_empty 1, o_rd_pempty 1.
REQ-032 While i_wr_rstn is low, the write side SHALL be held in reset: write pointer 0, o_wr_full 0, o_wr_pfull 0, o_wr_remain 2^AW.
REQ-033 A read reset mid-packet SHALL discard the captured packet's unconsumed lanes; the FIFO contents SHALL be undefined until both resets have been applied together.

Verification
REQ-034 Bench SHALL cover: single write i_wr_en=4'b0101, data lanes 0xA0/0xB1/0xC2/0xD3, then i_rd_req=3'b001 held -> reader0 receives 0xA0 then 0xC2, exactly one pop, o_rd_empty returns 1.
REQ-035 Bench SHALL cover: 16 writes of 4'b1111 with AW=4 -> o_wr_full=1 after sync and o_wr_remain=0; a 17th write gives o_wr_ack=0 and no pointer change.
REQ-036 Bench SHALL cover: i_rd_req=3'b111 constant over one 4-lane packet -> grants go r0,r1,r2,r0 with lane data in order 0..3.
REQ-037 Bench SHALL cover: 40 packets with wr_clk:rd_clk ratios 3:1 and 1:3 and random masks -> scoreboard matches every lane in order, pointers wrap twice, no loss.
REQ-038 Bench SHALL cover: i_rd_rstn asserted after 1 of 3 lanes consumed -> all read outputs 0 next edge, state IDLE, no X on flags.
REQ-039 Bench SHALL cover: level stepping 3->5 with PEMPTY_TH=4 -> o_rd_pempty falls after sync latency of at most 3 rd_clk cycles.
